// File: rtl/rcs_serial.sv
// Digit-serial ripple subtractor/adder: one DIGIT-bit slice per clock,
// with the borrow/carry held in a register between slices.
module rcs_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    input  logic             add_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if ((WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("rcs_serial: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             add_q, add_d;
    logic             c_q, c_d;
    logic             am_q, am_d;
    logic             bm_q, bm_d;

    logic [DIGIT-1:0] slice;
    logic             chain_c;

    // Operands shift right one digit per slice, so the live digit is
    // always at the bottom and no variable indexing is needed.
    always_comb begin
        logic c;
        c     = c_q;
        slice = '0;
        for (int i = 0; i < DIGIT; i++) begin
            slice[i] = a_q[i] ^ b_q[i] ^ c;
            if (add_q) begin
                c = (a_q[i] & b_q[i]) | (a_q[i] & c) | (b_q[i] & c);
            end else begin
                c = (~a_q[i] & b_q[i]) | (~a_q[i] & c) | (b_q[i] & c);
            end
        end
        chain_c = c;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        idx_d   = idx_q;
        add_d   = add_q;
        c_d     = c_q;
        am_d    = am_q;
        bm_d    = bm_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    add_d   = add_mode;
                    c_d     = borrow_in;
                    am_d    = a[WIDTH-1];
                    bm_d    = b[WIDTH-1];
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d    = a_q >> DIGIT;
                b_d    = b_q >> DIGIT;
                // Result digits enter at the top and drift down.
                diff_d = (diff_q >> DIGIT)
                       | (WIDTH'(slice) << (WIDTH - DIGIT));
                c_d    = chain_c;
                idx_d  = idx_q + 1'b1;
                if (idx_q == IW'(NDIG - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            idx_q   <= '0;
            add_q   <= 1'b0;
            c_q     <= 1'b0;
            am_q    <= 1'b0;
            bm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            idx_q   <= idx_d;
            add_q   <= add_d;
            c_q     <= c_d;
            am_q    <= am_d;
            bm_q    <= bm_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign borrow    = c_q;
    assign overflow  = add_q
                     ? ((am_q == bm_q) && (diff_q[WIDTH-1] != am_q))
                     : ((am_q != bm_q) && (diff_q[WIDTH-1] != am_q));

endmodule

// File: tb/tb_rcs_serial.sv
// Scoreboard bench for rcs_serial at DIGIT = 4, 1 and 16 (WIDTH = 16),
// directed cases followed by random operations against an integer model.
module tb_rcs_serial;

    typedef struct {
        logic [15:0] d;
        logic        c;
        logic        v;
        time         t;
    } exp_t;

    int  n_vec = 0;
    int  n_bad = 0;
    bit  done_v [3];
    logic clk = 1'b0;

    always #5 clk = ~clk;

    function automatic void chk(string nm, int dg,
                                logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s (DIGIT=%0d) t=%0t: got 0x%0h, expected 0x%0h",
                     nm, dg, $time, act, req);
        end
    endfunction

    function automatic exp_t mk(logic [15:0] d, logic c, logic v);
        exp_t e;
        e.d = d;
        e.c = c;
        e.v = v;
        e.t = 0;
        return e;
    endfunction

    // Plain integer arithmetic: unsigned result for diff/borrow,
    // signed result range for overflow.
    function automatic exp_t model(logic [15:0] a, logic [15:0] b,
                                   logic ci, logic md);
        exp_t   e;
        longint ua, ub, sa, sb, lc, ur, sr;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lc = longint'(ci);
        if (md) begin
            ur  = ua + ub + lc;
            sr  = sa + sb + lc;
            e.c = (ur > 65535);
        end else begin
            ur  = ua - ub - lc;
            sr  = sa - sb - lc;
            e.c = (ur < 0);
        end
        e.d = ur[15:0];
        e.v = (sr > 32767) || (sr < -32768);
        e.t = 0;
        return e;
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int DG   = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
        localparam int NDIG = 16 / DG;

        logic        reset_n, in_valid, in_ready, borrow_in, add_mode;
        logic        out_valid, out_ready, borrow, overflow;
        logic [15:0] a, b, diff;

        exp_t q [$];
        exp_t cur;
        bit   have = 1'b0;

        rcs_serial #(.WIDTH(16), .DIGIT(DG)) dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .borrow_in (borrow_in),
            .add_mode  (add_mode),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .diff      (diff),
            .borrow    (borrow),
            .overflow  (overflow)
        );

        always @(negedge clk) begin
            if (reset_n && out_valid) begin
                if (!have) begin
                    if (q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL spurious_out_valid (DIGIT=%0d) t=%0t: got 1, expected 0",
                                 DG, $time);
                    end else begin
                        cur  = q.pop_front();
                        have = 1'b1;
                        chk("latency", DG, 32'($time - cur.t),
                            32'(NDIG * 10 + 5));
                    end
                end
                if (have) begin
                    chk("diff", DG, 32'(diff), 32'(cur.d));
                    chk("borrow", DG, 32'(borrow), 32'(cur.c));
                    chk("overflow", DG, 32'(overflow), 32'(cur.v));
                    if (out_ready) have = 1'b0;
                end
            end
        end

        // Called and returns at #1 after a rising edge.
        task automatic do_op(input logic [15:0] ta, input logic [15:0] tb,
                             input logic tci, input logic tmd,
                             input int hold, input exp_t e);
            int k;
            k = 0;
            while (!in_ready && k < 100) begin
                @(posedge clk); #1; k++;
            end
            chk("in_ready_wait", DG, 32'(in_ready), 32'(1));
            a         = ta;
            b         = tb;
            borrow_in = tci;
            add_mode  = tmd;
            in_valid  = 1'b1;
            @(posedge clk);
            e.t = $time;
            q.push_back(e);
            #1;
            k = 0;
            while (!out_valid && k < 100) begin
                in_valid  = 1'($urandom);
                a         = 16'($urandom);
                b         = 16'($urandom);
                borrow_in = 1'($urandom);
                add_mode  = 1'($urandom);
                @(posedge clk); #1; k++;
            end
            chk("out_valid_wait", DG, 32'(out_valid), 32'(1));
            for (int h = 0; h < hold; h++) begin
                chk("in_ready_done", DG, 32'(in_ready), 32'(0));
                in_valid = 1'($urandom);
                a        = 16'($urandom);
                b        = 16'($urandom);
                @(posedge clk); #1;
            end
            chk("in_ready_done", DG, 32'(in_ready), 32'(0));
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk("in_ready_after", DG, 32'(in_ready), 32'(1));
            chk("out_valid_after", DG, 32'(out_valid), 32'(0));
        endtask

        initial begin
            reset_n   = 1'b0;
            in_valid  = 1'b0;
            out_ready = 1'b0;
            a         = 16'hDEAD;
            b         = 16'hBEEF;
            borrow_in = 1'b1;
            add_mode  = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            reset_n = 1'b1;
            chk("rst_in_ready", DG, 32'(in_ready), 32'(1));
            chk("rst_out_valid", DG, 32'(out_valid), 32'(0));
            chk("rst_diff", DG, 32'(diff), 32'(0));
            chk("rst_borrow", DG, 32'(borrow), 32'(0));
            chk("rst_overflow", DG, 32'(overflow), 32'(0));

            do_op(16'h1234, 16'h0234, 1'b0, 1'b0, 0, mk(16'h1000, 1'b0, 1'b0));
            do_op(16'h0005, 16'h0003, 1'b1, 1'b0, 1, mk(16'h0001, 1'b0, 1'b0));
            do_op(16'h0000, 16'h0001, 1'b0, 1'b0, 0, mk(16'hFFFF, 1'b1, 1'b0));
            do_op(16'h8000, 16'h0001, 1'b0, 1'b0, 0, mk(16'h7FFF, 1'b0, 1'b1));
            do_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 0, mk(16'h8000, 1'b0, 1'b1));
            do_op(16'hFFFF, 16'h0001, 1'b1, 1'b1, 0, mk(16'h0001, 1'b1, 1'b0));
            do_op(16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 5, mk(16'h4B4B, 1'b0, 1'b1));

            // Abort an operation: reset lands on its 2nd RUN cycle
            // (the only RUN cycle when the whole word is one digit).
            a         = 16'h4321;
            b         = 16'h1111;
            borrow_in = 1'b0;
            add_mode  = 1'b0;
            in_valid  = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (NDIG > 1) begin
                @(posedge clk); #1;
            end
            reset_n = 1'b0;
            @(posedge clk); #1;
            reset_n = 1'b1;
            chk("abort_in_ready", DG, 32'(in_ready), 32'(1));
            chk("abort_out_valid", DG, 32'(out_valid), 32'(0));
            chk("abort_diff", DG, 32'(diff), 32'(0));

            do_op(16'h00FF, 16'h000F, 1'b0, 1'b0, 0, mk(16'h00F0, 1'b0, 1'b0));

            for (int i = 0; i < 1000; i++) begin
                logic [15:0] ra, rb;
                logic        rc, rm;
                ra = pick();
                rb = pick();
                rc = 1'($urandom);
                rm = 1'($urandom);
                do_op(ra, rb, rc, rm, int'($urandom_range(0, 2)),
                      model(ra, rb, rc, rm));
            end
            done_v[g] = 1'b1;
        end
    end

    initial begin
        while (!(done_v[0] && done_v[1] && done_v[2]) && $time < 900000)
            @(posedge clk);
        if (!(done_v[0] && done_v[1] && done_v[2])) begin
            n_vec++;
            n_bad++;
            $display("FAIL global_timeout t=%0t: got unfinished, expected all done",
                     $time);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rcs_serial.md
Name: rcs_serial

Overview:
- Parametrised, multi-cycle digit-serial ripple subtractor/adder; next generation of the 4-bit ripple-carry subtractor.
- Processes one DIGIT-bit slice of a WIDTH-bit operand pair per clock. The borrow or carry is held in a register between slices.
- Adds an add/subtract mode, a signed-overflow flag and valid/ready handshakes on input and output.
- Sits in the arithmetic datapath where area matters more than latency.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle (1..WIDTH). NDIG = WIDTH/DIGIT.

Ports:
- clk  input  1  clock, all logic on rising edge
- reset_n  input  1  synchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend / addend
- b  input  WIDTH  subtrahend / addend
- borrow_in  input  1  borrow-in (sub) or carry-in (add)
- add_mode  input  1  0 = a-b-borrow_in, 1 = a+b+borrow_in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  result
- borrow  output  1  borrow-out (sub) or carry-out (add) from the MSB
- overflow  output  1  signed overflow

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (reset_n=0 at a clk edge):
  - state=IDLE, in_ready=1 after the edge, out_valid=0.
  - diff=0, borrow=0, overflow=0; internal index and borrow register cleared.
  - Reset mid-RUN or in DONE aborts the operation; no out_valid is produced for it.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: latch a, b, borrow_in and add_mode; idx=0; borrow register = borrow_in; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle computes slice [idx*DIGIT +: DIGIT] through a DIGIT-bit ripple chain seeded by the borrow register.
  - Per bit, sub: d=a^b^c, bo=(~a&b)|(~a&c)|(b&c). Add: s=a^b^c, co=(a&b)|(a&c)|(b&c).
  - Writes the slice into diff, stores the chain output into the borrow register, idx++.
  - After the slice with idx==NDIG-1: go to DONE.
  - Input pins are ignored during RUN; the latched copies are used.
- DONE:
  - out_valid=1. diff, borrow and overflow are stable, and held for as long as out_ready=0.
  - in_ready=0: in_valid is ignored and not queued.
  - On out_valid&out_ready: go to IDLE; out_valid=0 and in_ready=1 after that edge.
- Latency: with operands accepted at edge E0, out_valid rises after edge E0+NDIG.
- Throughput: minimum one operation per NDIG+2 cycles (IDLE, NDIG RUN cycles, DONE).
- borrow = final chain output. Sub: 1 iff a < b+borrow_in (unsigned). Add: unsigned carry.
- overflow, computed from latched MSBs aM, bM and result MSB rM:
  - sub: (aM!=bM)&(rM!=aM)
  - add: (aM==bM)&(rM!=aM)
- diff is internal scratch during RUN; its value is defined only while out_valid=1.
- DIGIT==WIDTH is legal: single RUN cycle, latency 1.
- WIDTH%DIGIT!=0 must fail at elaboration.
- Wrap-around is modulo 2^WIDTH, e.g. 0-1 = all ones with borrow=1.

Test Plan (WIDTH=16, DIGIT=4):
1. sub 0x1234-0x0234, borrow_in=0 -> diff=0x1000, borrow=0, overflow=0; out_valid exactly 4 edges after accept; 0x0005-0x0003, borrow_in=1 -> 0x0001.
2. sub 0x0000-0x0001 -> diff=0xFFFF, borrow=1, overflow=0; sub 0x8000-0x0001 -> 0x7FFF, borrow=0, overflow=1.
3. add 0x7FFF+0x0001, cin=0 -> 0x8000, borrow(carry)=0, overflow=1; add 0xFFFF+0x0001, cin=1 -> 0x0001, carry=1, overflow=0.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE, toggle in_valid and change a/b -> diff/borrow/overflow unchanged, in_ready=0, no second op; release -> in_ready=1 next cycle and next op correct.
5. Reset mid-RUN: assert reset_n=0 on the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, diff=0; a following 0x00FF-0x000F returns 0x00F0.
6. Parameter sweep: DIGIT=1, 4, 16 against a reference model over 1000 random ops in both modes -> all match; latency = NDIG.
